// File: rtl/dp_pkg.sv
// Shared types and helpers for the dining-philosophers marking controller.
package dp_pkg;

    localparam int DP_MAX_PHIL = 16;
    localparam int DP_CNT_W    = 16;

    typedef enum logic {
        THINK = 1'b0,
        EAT   = 1'b1
    } phil_state_e;

    // Fork to the right of philosopher i in a table of n seats.
    function automatic int right_fork(input int i, input int n);
        return (i + 1) % n;
    endfunction

endpackage

// File: rtl/dp_rr_arbiter.sv
// Round-robin take arbiter: scans eligible philosophers from ptr and grants a
// maximal set whose fork pairs do not overlap.
module dp_rr_arbiter
    import dp_pkg::*;
#(
    parameter int N  = 5,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  elig,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic          any_gnt,
    output logic [PW-1:0] first_idx
);

    logic [N-1:0] claimed;
    int           idx;
    int           rf;

    always_comb begin
        gnt       = '0;
        claimed   = '0;
        any_gnt   = 1'b0;
        first_idx = '0;
        idx       = 0;
        rf        = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N) idx = idx - N;
            rf = right_fork(idx, N);
            if (elig[idx] && !claimed[idx] && !claimed[rf]) begin
                gnt[idx]     = 1'b1;
                claimed[idx] = 1'b1;
                claimed[rf]  = 1'b1;
                if (!any_gnt) begin
                    any_gnt   = 1'b1;
                    first_idx = PW'(idx);
                end
            end
        end
    end

endmodule

// File: rtl/dining_phil_mealy_fsm.sv
// Petri-net marking controller for N_PHIL dining philosophers with Mealy grants.
// Optional starvation monitor built when DP_STARVE_MON_EN is defined.
module dining_phil_mealy_fsm
    import dp_pkg::*;
#(
    parameter int N_PHIL     = 5,
    parameter int STARVE_LIM = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_PHIL-1:0] take_req,
    input  logic [N_PHIL-1:0] rel_req,
    output logic [N_PHIL-1:0] take_gnt,
    output logic [N_PHIL-1:0] rel_gnt,
    output logic [N_PHIL-1:0] fork_free,
    output logic [N_PHIL-1:0] eating,
    output logic              illegal_err,
    output logic [N_PHIL-1:0] starve
);

    localparam int RR_W = $clog2(N_PHIL);

    if (N_PHIL < 2 || N_PHIL > DP_MAX_PHIL) begin : g_bad_n
        $error("N_PHIL out of range");
    end
    if (STARVE_LIM < 1 || STARVE_LIM > 65535) begin : g_bad_lim
        $error("STARVE_LIM out of range");
    end

    phil_state_e       phil_st [N_PHIL];
    logic [N_PHIL-1:0] fork_q;
    logic [RR_W-1:0]   rr_ptr;
    logic              err_q;

    logic [N_PHIL-1:0] elig, arb_gnt, take_forks, rel_forks, fork_exp;
    logic              any_gnt, illegal;
    logic [RR_W-1:0]   first_idx;

    // Request/grant: a req bit may be held across cycles; the firing happens at
    // the edge closing any cycle in which its gnt bit is high. No other handshake.
    always_comb begin
        eating     = '0;
        elig       = '0;
        take_forks = '0;
        rel_forks  = '0;
        fork_exp   = '0;
        for (int i = 0; i < N_PHIL; i++) begin
            eating[i] = (phil_st[i] == EAT);
        end
        rel_gnt  = reset ? (rel_req & eating & ~take_req) : '0;
        for (int i = 0; i < N_PHIL; i++) begin
            elig[i] = take_req[i] & ~eating[i] & ~rel_req[i]
                    & fork_q[i] & fork_q[right_fork(i, N_PHIL)];
        end
        take_gnt = reset ? arb_gnt : '0;
        for (int i = 0; i < N_PHIL; i++) begin
            take_forks[i]                    = take_forks[i] | take_gnt[i];
            take_forks[right_fork(i, N_PHIL)] = take_forks[right_fork(i, N_PHIL)] | take_gnt[i];
            rel_forks[i]                     = rel_forks[i] | rel_gnt[i];
            rel_forks[right_fork(i, N_PHIL)]  = rel_forks[right_fork(i, N_PHIL)] | rel_gnt[i];
            fork_exp[i] = ~(eating[i] | eating[(i + N_PHIL - 1) % N_PHIL]);
        end
        illegal = |((take_req & eating) | (rel_req & ~eating) | (take_req & rel_req));
    end

    dp_rr_arbiter #(.N(N_PHIL), .PW(RR_W)) u_arb (
        .elig      (elig),
        .ptr       (rr_ptr),
        .gnt       (arb_gnt),
        .any_gnt   (any_gnt),
        .first_idx (first_idx)
    );

    // Taken and released fork sets are disjoint, so forks need no priority rule.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N_PHIL; i++) phil_st[i] <= THINK;
            fork_q <= '1;
            rr_ptr <= '0;
            err_q  <= 1'b0;
        end else begin
            for (int i = 0; i < N_PHIL; i++) begin
                if (take_gnt[i])     phil_st[i] <= EAT;
                else if (rel_gnt[i]) phil_st[i] <= THINK;
            end
            fork_q <= (fork_q & ~take_forks) | rel_forks;
            if (any_gnt)
                rr_ptr <= (first_idx == RR_W'(N_PHIL - 1)) ? '0 : first_idx + RR_W'(1);
            if (illegal) err_q <= 1'b1;
        end
    end

    assign fork_free   = fork_q;
    assign illegal_err = err_q;

    a_fork_marking: assert property (@(posedge clk) disable iff (!reset) fork_free == fork_exp);

`ifdef DP_STARVE_MON_EN
    localparam logic [DP_CNT_W-1:0] LIM = DP_CNT_W'(STARVE_LIM);
    logic [DP_CNT_W-1:0] wait_cnt [N_PHIL];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N_PHIL; i++) wait_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < N_PHIL; i++) begin
                if (take_req[i] && !take_gnt[i]) begin
                    if (wait_cnt[i] != LIM) wait_cnt[i] <= wait_cnt[i] + 1'b1;
                end else begin
                    wait_cnt[i] <= '0;
                end
            end
        end
    end

    always_comb begin
        starve = '0;
        for (int i = 0; i < N_PHIL; i++) starve[i] = (wait_cnt[i] == LIM);
    end
`else
    assign starve = '0;
`endif

endmodule
